// File: rtl/pixel_reorder_buffer.sv
// Reorders out-of-order (x, y, colour) results from NUM_CH pixel engines into raster order.
// Results are held in a small content-addressed store and leave through a registered valid/ready output.
module pixel_reorder_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int RGB_SIZE   = 24,
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 16,
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  localparam int IDX_W     = $clog2(DEPTH),
  localparam int OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_x,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_y,
  input  logic [NUM_CH*RGB_SIZE-1:0]   in_colour,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [RGB_SIZE-1:0]          out_colour,
  output logic [DATA_WIDTH-1:0]        out_x,
  output logic [DATA_WIDTH-1:0]        out_y,
  output logic                         out_last,
  output logic [OCC_W-1:0]             occupancy,
  output logic                         full,
  output logic [15:0]                  drop_count,
  output logic                         deadlock
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [DEPTH-1:0]      slot_valid;
  logic [DATA_WIDTH-1:0] slot_x [DEPTH];
  logic [DATA_WIDTH-1:0] slot_y [DEPTH];
  logic [RGB_SIZE-1:0]   slot_c [DEPTH];

  logic [DATA_WIDTH-1:0] ex, ey;
  logic [CH_W-1:0]       rr_ptr, grant, cand;
  logic                  grant_found;
  logic [DATA_WIDTH-1:0] sel_x, sel_y;
  logic [RGB_SIZE-1:0]   sel_c;
  logic                  accept, in_range, dup, do_write, do_read;
  logic                  match_found, free_found;
  logic [IDX_W-1:0]      match_idx, free_idx;
  logic [OCC_W-1:0]      occ;

  // Round-robin search starting at rr_ptr.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    cand        = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = CH_W'((int'(rr_ptr) + k) % NUM_CH);
      if (!grant_found && in_valid[cand]) begin
        grant_found = 1'b1;
        grant       = cand;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (grant_found && !full) in_ready[grant] = 1'b1;
  end

  assign sel_x    = in_x[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_y    = in_y[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_c    = in_colour[int'(grant)*RGB_SIZE +: RGB_SIZE];
  assign accept   = grant_found && !full;
  assign in_range = (sel_x < DATA_WIDTH'(SCREEN_W)) && (sel_y < DATA_WIDTH'(SCREEN_H));

  // The pixel sitting in the output register also counts as already seen.
  always_comb begin
    dup = out_valid && (out_x == sel_x) && (out_y == sel_y);
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i] && slot_x[i] == sel_x && slot_y[i] == sel_y) dup = 1'b1;
    end
  end

  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    occ         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + OCC_W'(slot_valid[i]);
      if (!match_found && slot_valid[i] && slot_x[i] == ex && slot_y[i] == ey) begin
        match_found = 1'b1;
        match_idx   = IDX_W'(i);
      end
      if (!free_found && !slot_valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign occupancy = occ;
  assign full      = (occ == OCC_W'(DEPTH));
  assign do_write  = accept && in_range && !dup && free_found;
  assign do_read   = match_found && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (do_write) begin
      slot_x[free_idx] <= sel_x;
      slot_y[free_idx] <= sel_y;
      slot_c[free_idx] <= sel_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_valid <= '0;
      ex         <= '0;
      ey         <= '0;
      rr_ptr     <= '0;
      out_valid  <= 1'b0;
      out_colour <= '0;
      out_x      <= '0;
      out_y      <= '0;
      out_last   <= 1'b0;
      drop_count <= '0;
      deadlock   <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
        if (!(in_range && !dup) && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
      if (do_write) slot_valid[free_idx] <= 1'b1;
      if (do_read) begin
        slot_valid[match_idx] <= 1'b0;
        out_valid  <= 1'b1;
        out_colour <= slot_c[match_idx];
        out_x      <= slot_x[match_idx];
        out_y      <= slot_y[match_idx];
        out_last   <= (ex == DATA_WIDTH'(SCREEN_W - 1)) && (ey == DATA_WIDTH'(SCREEN_H - 1));
        if (ex == DATA_WIDTH'(SCREEN_W - 1)) begin
          ex <= '0;
          ey <= (ey == DATA_WIDTH'(SCREEN_H - 1)) ? '0 : ey + 1'b1;
        end else begin
          ex <= ex + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (full && !match_found && !out_valid) deadlock <= 1'b1;
    end
  end

endmodule
